// File: rtl/alu_mul_seq_if.sv
// Handshake and shared-ALU bus of the shift-add multiplier sequencer.
interface alu_mul_seq_if;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] result;
    logic        busy;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [3:0]  alu_op;
    logic [31:0] alu_out;

    modport slave (
        input  start_valid, a, b, res_ready, alu_out,
        output start_ready, res_valid, result, busy, alu_in1, alu_in2, alu_op
    );

    modport master (
        output start_valid, a, b, res_ready, alu_out,
        input  start_ready, res_valid, result, busy, alu_in1, alu_in2, alu_op
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Sequential 32x32 shift-add multiplier (low 32 bits) that borrows a shared ALU
// for its additions; terminates early once the remaining multiplier bits are zero.
module alu_mul_seq (
    input  logic         clk,
    input  logic         reset,
    alu_mul_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_PASS = 4'b1000;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [4:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        acc_d           = acc_q;
        mcand_d         = mcand_q;
        mplier_d        = mplier_q;
        cnt_d           = cnt_q;
        bus.start_ready = 1'b0;
        bus.res_valid   = 1'b0;
        bus.result      = '0;
        bus.busy        = 1'b1;
        bus.alu_op      = OP_PASS;
        bus.alu_in1     = '0;
        bus.alu_in2     = '0;

        case (state_q)
            IDLE: begin
                bus.start_ready = 1'b1;
                bus.busy        = 1'b0;
                if (bus.start_valid) begin
                    acc_d    = '0;
                    mcand_d  = bus.a;
                    mplier_d = bus.b;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                bus.alu_op  = OP_ADD;
                bus.alu_in1 = acc_q;
                bus.alu_in2 = mcand_q;
                if (mplier_q[0]) acc_d = bus.alu_out;
                mcand_d  = {mcand_q[30:0], 1'b0};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                // Exit test looks at the shifted multiplier, so b=0 still spends one RUN cycle.
                if ((mplier_q >> 1) == '0 || cnt_q == 5'd31) state_d = DONE;
            end
            DONE: begin
                bus.res_valid = 1'b1;
                bus.result    = acc_q;
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed vector bench for alu_mul_seq with a behavioural shared ALU.
module tb_alu_mul_seq;
    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_fail = 0;

    alu_mul_seq_if ifc ();

    alu_mul_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    assign ifc.alu_out = (ifc.alu_op == 4'b0010) ? ifc.alu_in1 + ifc.alu_in2 :
                         (ifc.alu_op == 4'b1000) ? ifc.alu_in1 : 32'h0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_runs;
        int          hold;
        bit          chg_ops;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_op(input vec_t v);
        int runs;
        int bad_op;
        int t;
        @(negedge clk);
        chk("idle_start_ready", {31'b0, ifc.start_ready}, 32'd1);
        chk("idle_busy", {31'b0, ifc.busy}, 32'd0);
        ifc.a           = v.a;
        ifc.b           = v.b;
        ifc.start_valid = 1'b1;
        ifc.res_ready   = (v.hold == 0);
        @(posedge clk);
        #1;
        if (v.chg_ops) begin
            ifc.a = 32'h0000_0055;
            ifc.b = 32'h0000_0077;
        end else begin
            ifc.start_valid = 1'b0;
            ifc.a           = 32'hA5A5_A5A5;
            ifc.b           = 32'h5A5A_5A5A;
        end
        runs   = 0;
        bad_op = 0;
        t      = 0;
        @(negedge clk);
        while (!ifc.res_valid && t < 40) begin
            runs++;
            if (ifc.alu_op !== 4'b0010 || ifc.busy !== 1'b1 || ifc.start_ready !== 1'b0 ||
                ifc.result !== 32'h0) bad_op++;
            @(negedge clk);
            t++;
        end
        chk("run_cycles", runs, v.exp_runs);
        chk("run_outputs", bad_op, 0);
        chk("res_valid", {31'b0, ifc.res_valid}, 32'd1);
        chk("result", ifc.result, v.exp_res);
        chk("done_alu_op", {28'b0, ifc.alu_op}, 32'h8);
        for (int i = 0; i < v.hold; i++) begin
            chk("hold_valid", {31'b0, ifc.res_valid}, 32'd1);
            chk("hold_result", ifc.result, v.exp_res);
            chk("hold_start_ready", {31'b0, ifc.start_ready}, 32'd0);
            @(negedge clk);
        end
        ifc.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.start_valid = 1'b0;
        chk("post_valid", {31'b0, ifc.res_valid}, 32'd0);
        chk("post_result", ifc.result, 32'h0);
        chk("post_busy", {31'b0, ifc.busy}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'd3,          32'd5,          32'd15,         3,  0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  32, 0, 1'b0};
        vecs[2] = '{32'h1234_5678,  32'd0,          32'd0,          1,  0, 1'b0};
        vecs[3] = '{32'h8000_0000,  32'd2,          32'd0,          2,  0, 1'b0};
        vecs[4] = '{32'd7,          32'd6,          32'd42,         3,  5, 1'b0};
        vecs[5] = '{32'd2,          32'd9,          32'd18,         4,  0, 1'b1};
        vecs[6] = '{32'h0000_0055,  32'h0000_0077,  32'h0000_2783,  7,  0, 1'b0};
        vecs[7] = '{32'hDEAD_BEEF,  32'd1,          32'hDEAD_BEEF,  1,  0, 1'b0};

        reset           = 1'b1;
        ifc.start_valid = 1'b0;
        ifc.res_ready   = 1'b0;
        ifc.a           = '0;
        ifc.b           = '0;
        #3;
        chk("rst_start_ready", {31'b0, ifc.start_ready}, 32'd1);
        chk("rst_res_valid", {31'b0, ifc.res_valid}, 32'd0);
        chk("rst_busy", {31'b0, ifc.busy}, 32'd0);
        chk("rst_result", ifc.result, 32'h0);
        chk("rst_alu_op", {28'b0, ifc.alu_op}, 32'h8);
        chk("rst_alu_in1", ifc.alu_in1, 32'h0);
        chk("rst_alu_in2", ifc.alu_in2, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) do_op(vecs[i]);

        // Reset pulsed while an operation is in RUN with cnt=4.
        @(negedge clk);
        ifc.a           = 32'd5;
        ifc.b           = 32'h0000_00FF;
        ifc.start_valid = 1'b1;
        ifc.res_ready   = 1'b1;
        @(posedge clk);
        #1;
        ifc.start_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("abort_cnt", {27'b0, dut.cnt_q}, 32'd4);
        chk("abort_busy_before", {31'b0, ifc.busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'b0, ifc.busy}, 32'd0);
        chk("abort_start_ready", {31'b0, ifc.start_ready}, 32'd1);
        chk("abort_res_valid", {31'b0, ifc.res_valid}, 32'd0);
        chk("abort_result", ifc.result, 32'h0);
        chk("abort_alu_op", {28'b0, ifc.alu_op}, 32'h8);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("after_abort_valid", {31'b0, ifc.res_valid}, 32'd0);
        do_op('{32'd10, 32'd10, 32'd100, 4, 0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
